mci_ctrl_fsm: RTL

Multi-cycle control unit for the MCI datapath. It sequences instruction fetch from the combinational instruction memory, decode, execute, data-memory access and register writeback. It drives every datapath mux select and write enable from a Moore state machine. Data-memory accesses are stretched by a ready handshake. PC is a word index, so the fetch increment is +1.

---
 rtl/mci_ctrl_pkg.sv | 58 +++++
 rtl/mci_ctrl_decode.sv | 66 ++++++
 rtl/mci_ctrl_fsm.sv | 99 +++++++++
 3 files changed

// File: rtl/mci_ctrl_pkg.sv
// Shared encodings for the MCI multi-cycle control unit: states, opcodes,
// mux-select codes and the decoded control vector.
package mci_ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int ST_W  = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_BEQ     = 4'd4,
    S_ADDR    = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_JUMP    = 4'd9,
    S_ILLEGAL = 4'd10
  } state_e;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_ONE    = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_BR = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mci_ctrl_decode.sv
// Pure Moore decode: maps the current state onto the datapath control vector.
// Unused state encodings decode to all-zero controls.
module mci_ctrl_decode
  import mci_ctrl_pkg::*;
(
  input  logic [ST_W-1:0] state_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRC_B_ONE;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.pc_source = PC_SRC_ALU;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRC_B_IMM_BR;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_REG;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRC_B_REG;
        ctrl_o.alu_op        = ALU_OP_SUB;
        ctrl_o.pc_source     = PC_SRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
      S_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_source = PC_SRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
      end
      S_ILLEGAL: ctrl_o.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mci_ctrl_fsm.sv
// MCI multi-cycle control unit: state register, next-state logic, pc_en gating.
// Optional MCI_PERF_CNT_EN adds free-running cycle and instruction counters.
module mci_ctrl_fsm
  import mci_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state_o
`ifdef MCI_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      instr_cnt
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BEQ;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
      default:  state_d = S_FETCH;
    endcase
  end

  mci_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Reset forces every output low even before the first reset edge lands.
  assign pc_en      = ~rst & (ctrl.pc_write | (ctrl.pc_write_cond & zero));
  assign ir_write   = ~rst & ctrl.ir_write;
  assign iord       = ~rst & ctrl.iord;
  assign mem_read   = ~rst & ctrl.mem_read;
  assign mem_write  = ~rst & ctrl.mem_write;
  assign reg_write  = ~rst & ctrl.reg_write;
  assign reg_dst    = ~rst & ctrl.reg_dst;
  assign mem_to_reg = ~rst & ctrl.mem_to_reg;
  assign alu_src_a  = ~rst & ctrl.alu_src_a;
  assign alu_src_b  = rst ? 2'b00 : ctrl.alu_src_b;
  assign alu_op     = rst ? 2'b00 : ctrl.alu_op;
  assign pc_source  = rst ? 2'b00 : ctrl.pc_source;
  assign illegal_op = ~rst & ctrl.illegal_op;
  assign state_o    = rst ? '0 : state_q;

`ifdef MCI_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q == S_FETCH) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
